// File: rtl/vga_timing_pkg.sv
// VGA timing constants shared by the sync generator and its counters.
// Includes a range check for counter parameters.
package vga_timing_pkg;

  localparam int COUNTER_WIDTH = 11;

  localparam int H_VISIBLE = 1024;
  localparam int H_FRONT   = 24;
  localparam int H_SYNC    = 136;
  localparam int H_BACK    = 144;
  localparam int H_TOTAL   =
    H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_WIDTH   = 10;
  localparam int V_VISIBLE = 768;
  localparam int V_FRONT   = 3;
  localparam int V_SYNC    = 6;
  localparam int V_BACK    = 29;
  localparam int V_TOTAL   =
    V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // A counter of n states fits in width bits when 2 <= n <= 2**width.
  function automatic bit limit_ok(
    input int width,
    input int n
  );
    longint cap;
    cap = longint'(1) << width;
    return (n >= 2) && (longint'(n) <= cap);
  endfunction

endpackage

// File: rtl/vga_counter.sv
// Modulo-COUNT_LIMIT up-counter with enable and cascade carry.
// Base timing element for horizontal and vertical VGA position.
module vga_counter
  import vga_timing_pkg::*;
#(
  parameter int WIDTH       = COUNTER_WIDTH,
  parameter int COUNT_LIMIT = H_TOTAL
) (
  input  logic             control_clock,
  input  logic             control_reset,
  input  logic             counter_enable,
  output logic [WIDTH-1:0] counter_output,
  output logic             counter_terminal,
  output logic             counter_carry
);

  if (!limit_ok(WIDTH, COUNT_LIMIT)) begin : g_bad_limit
    $error("vga_counter: COUNT_LIMIT outside 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] LAST = WIDTH'(COUNT_LIMIT - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;
  logic             w_terminal;

  assign w_terminal = (r_count == LAST);

  // With COUNT_LIMIT == 2**WIDTH the increment wraps on its own.
  assign w_next = w_terminal ? '0 : r_count + ONE;

  always_ff @(posedge control_clock) begin
    if (control_reset) begin
      r_count <= '0;
    end else if (counter_enable) begin
      r_count <= w_next;
    end
  end

  assign counter_output   = r_count;
  assign counter_terminal = w_terminal;
  assign counter_carry    = w_terminal & counter_enable;

endmodule

// File: tb/tb_vga_counter.sv
// Randomized self-checking bench for vga_counter.
// Covers defaults, small instances and two cascades.
module tb_vga_counter;

  localparam int HN = 1328;
  localparam int VN = 806;

  logic clk;
  logic rst;
  logic en_h;
  logic en_s4;
  logic en_s5;

  logic [10:0] h_out;
  logic        h_term;
  logic        h_carry;
  logic [9:0]  v_out;
  logic        v_term;
  logic        v_carry;
  logic [1:0]  s4_out;
  logic        s4_term;
  logic        s4_carry;
  logic [2:0]  s5_out;
  logic        s5_term;
  logic        s5_carry;
  logic [1:0]  c3_out;
  logic        c3_term;
  logic        c3_carry;

  int checks;
  int errors;

  int m_h, m_v, m_s4, m_s5, m_c3;

  vga_counter u_h (
    .control_clock   (clk),
    .control_reset   (rst),
    .counter_enable  (en_h),
    .counter_output  (h_out),
    .counter_terminal(h_term),
    .counter_carry   (h_carry)
  );

  vga_counter #(.WIDTH(10), .COUNT_LIMIT(VN)) u_v (
    .control_clock   (clk),
    .control_reset   (rst),
    .counter_enable  (h_carry),
    .counter_output  (v_out),
    .counter_terminal(v_term),
    .counter_carry   (v_carry)
  );

  vga_counter #(.WIDTH(2), .COUNT_LIMIT(4)) u_s4 (
    .control_clock   (clk),
    .control_reset   (rst),
    .counter_enable  (en_s4),
    .counter_output  (s4_out),
    .counter_terminal(s4_term),
    .counter_carry   (s4_carry)
  );

  vga_counter #(.WIDTH(3), .COUNT_LIMIT(5)) u_s5 (
    .control_clock   (clk),
    .control_reset   (rst),
    .counter_enable  (en_s5),
    .counter_output  (s5_out),
    .counter_terminal(s5_term),
    .counter_carry   (s5_carry)
  );

  vga_counter #(.WIDTH(2), .COUNT_LIMIT(3)) u_c3 (
    .control_clock   (clk),
    .control_reset   (rst),
    .counter_enable  (s5_carry),
    .counter_output  (c3_out),
    .counter_terminal(c3_term),
    .counter_carry   (c3_carry)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: each counter is "number of enabled edges since reset,
  // modulo its period"; a cascade advances when the feeder passes its last state.
  task automatic tick();
    bit hc;
    bit sc;
    @(posedge clk);
    if (rst) begin
      m_h = 0; m_v = 0; m_s4 = 0; m_s5 = 0; m_c3 = 0;
    end else begin
      hc = en_h && (m_h == HN - 1);
      sc = en_s5 && (m_s5 == 4);
      if (en_h)  m_h  = (m_h + 1) % HN;
      if (hc)    m_v  = (m_v + 1) % VN;
      if (en_s4) m_s4 = (m_s4 + 1) % 4;
      if (en_s5) m_s5 = (m_s5 + 1) % 5;
      if (sc)    m_c3 = (m_c3 + 1) % 3;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en_h = 1'b1; en_s4 = 1'b1; en_s5 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (h_out !== 11'd0 || h_term !== 1'b0 || h_carry !== 1'b0) begin
        errors++;
        $display("FAIL reset_h: out=%0d term=%b carry=%b required 0/0/0",
                 h_out, h_term, h_carry);
      end
      checks++;
      if (v_out !== 10'd0 || s4_out !== 2'd0 || s5_out !== 3'd0 ||
          c3_out !== 2'd0) begin
        errors++;
        $display("FAIL reset_others: v=%0d s4=%0d s5=%0d c3=%0d required 0",
                 v_out, s4_out, s5_out, c3_out);
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (h_out !== 11'(i)) begin
        errors++;
        $display("FAIL release_count: got %0d required %0d", h_out, i);
      end
    end
  endtask

  task automatic test_full_period();
    int pulses;
    int k;
    do_reset();
    en_h = 1'b1;
    pulses = 0;
    for (k = 1; k <= 3 * HN; k++) begin
      tick();
      checks++;
      if (h_out !== 11'(k % HN) ||
          h_term !== ((k % HN) == HN - 1)) begin
        errors++;
        $display("FAIL period_h k=%0d: out=%0d term=%b required %0d",
                 k, h_out, h_term, k % HN);
      end
      checks++;
      if (v_out !== 10'(k / HN)) begin
        errors++;
        $display("FAIL period_v k=%0d: got %0d required %0d",
                 k, v_out, k / HN);
      end
      if (k == HN - 1) begin
        checks++;
        if (h_out !== 11'd1327 || h_term !== 1'b1 || h_carry !== 1'b1) begin
          errors++;
          $display("FAIL terminal: out=%0d term=%b carry=%b required 1327/1/1",
                   h_out, h_term, h_carry);
        end
      end
      if (h_carry === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 3) begin
      errors++;
      $display("FAIL carry_pulses: got %0d required 3", pulses);
    end
  endtask

  task automatic test_enable_gating();
    int pat[6];
    int expv[6];
    pat  = '{1, 0, 0, 1, 0, 1};
    expv = '{1, 1, 1, 2, 2, 3};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      en_h = pat[i][0];
      tick();
      checks++;
      if (h_out !== 11'(expv[i])) begin
        errors++;
        $display("FAIL gating[%0d]: got %0d required %0d",
                 i, h_out, expv[i]);
      end
    end
    en_h = 1'b1;
    repeat (HN - 1 - 3) tick();
    en_h = 1'b0;
    #1;
    checks++;
    if (h_out !== 11'd1327 || h_term !== 1'b1 || h_carry !== 1'b0) begin
      errors++;
      $display("FAIL hold_terminal: out=%0d term=%b carry=%b required 1327/1/0",
               h_out, h_term, h_carry);
    end
    repeat (3) tick();
    checks++;
    if (h_out !== 11'd1327 || h_carry !== 1'b0 || v_out !== 10'd0) begin
      errors++;
      $display("FAIL hold_persist: out=%0d carry=%b v=%0d required 1327/0/0",
               h_out, h_carry, v_out);
    end
    en_h = 1'b1;
    #1;
    checks++;
    if (h_carry !== 1'b1) begin
      errors++;
      $display("FAIL carry_on_enable: got %b required 1", h_carry);
    end
    tick();
    checks++;
    if (h_out !== 11'd0 || v_out !== 10'd1) begin
      errors++;
      $display("FAIL wrap_after_hold: h=%0d v=%0d required 0/1", h_out, v_out);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    do_reset();
    en_h = 1'b1;
    repeat (700) tick();
    checks++;
    if (h_out !== 11'd700) begin
      errors++;
      $display("FAIL mid_700: got %0d required 700", h_out);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (h_out !== 11'd0) begin
      errors++;
      $display("FAIL mid_reset: got %0d required 0", h_out);
    end
    repeat (HN - 1) tick();
    checks++;
    if (h_out !== 11'd1327 || h_carry !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_term: out=%0d carry=%b required 1327/1",
               h_out, h_carry);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (h_out !== 11'd0 || v_out !== 10'd0) begin
      errors++;
      $display("FAIL term_reset: h=%0d v=%0d required 0/0", h_out, v_out);
    end
    pulses = 0;
    for (int k = 1; k <= HN; k++) begin
      if (h_carry === 1'b1) pulses++;
      tick();
      checks++;
      if (h_out !== 11'(k % HN)) begin
        errors++;
        $display("FAIL after_reset k=%0d: got %0d required %0d",
                 k, h_out, k % HN);
      end
    end
    checks++;
    if (pulses !== 1 || v_out !== 10'd1) begin
      errors++;
      $display("FAIL after_reset_wrap: pulses=%0d v=%0d required 1/1",
               pulses, v_out);
    end
  endtask

  task automatic test_small();
    en_s4 = 1'b1; en_s5 = 1'b1;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++;
      if (s4_out !== 2'(k % 4) || s5_out !== 3'(k % 5) ||
          c3_out !== 2'((k / 5) % 3)) begin
        errors++;
        $display("FAIL small_seq k=%0d: s4=%0d s5=%0d c3=%0d required %0d/%0d/%0d",
                 k, s4_out, s5_out, c3_out, k % 4, k % 5, (k / 5) % 3);
      end
    end
    for (int k = 0; k < 300; k++) begin
      en_s4 = 1'($urandom_range(0, 1));
      en_s5 = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (s4_out !== 2'(m_s4) || s5_out !== 3'(m_s5) ||
          c3_out !== 2'(m_c3) || s5_out > 3'd4 ||
          s4_carry !== (m_s4 == 3 && en_s4) ||
          s5_carry !== (m_s5 == 4 && en_s5)) begin
        errors++;
        $display("FAIL small_rand k=%0d: s4=%0d s5=%0d c3=%0d required %0d/%0d/%0d",
                 k, s4_out, s5_out, c3_out, m_s4, m_s5, m_c3);
      end
      tick();
    end
  endtask

  task automatic test_cascade();
    do_reset();
    en_h = 1'b1;
    for (int p = 1; p <= 5; p++) begin
      for (int k = 1; k <= HN; k++) begin
        tick();
        checks++;
        if (v_out !== 10'(k == HN ? p : p - 1) || v_term !== 1'b0) begin
          errors++;
          $display("FAIL cascade p=%0d k=%0d: v=%0d required %0d",
                   p, k, v_out, k == HN ? p : p - 1);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4000; k++) begin
      rst   = ($urandom_range(0, 999) == 0);
      en_h  = ($urandom_range(0, 7) != 0);
      en_s4 = 1'($urandom_range(0, 1));
      en_s5 = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (h_out !== 11'(m_h) || v_out !== 10'(m_v) ||
          h_term !== (m_h == HN - 1) ||
          h_carry !== (m_h == HN - 1 && en_h)) begin
        errors++;
        $display("FAIL random_h k=%0d: h=%0d v=%0d carry=%b required %0d/%0d",
                 k, h_out, v_out, h_carry, m_h, m_v);
      end
      checks++;
      if (s4_out !== 2'(m_s4) || s5_out !== 3'(m_s5) ||
          c3_out !== 2'(m_c3)) begin
        errors++;
        $display("FAIL random_small k=%0d: s4=%0d s5=%0d c3=%0d required %0d/%0d/%0d",
                 k, s4_out, s5_out, c3_out, m_s4, m_s5, m_c3);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_h = 0; m_v = 0; m_s4 = 0; m_s5 = 0; m_c3 = 0;
    rst = 1'b1; en_h = 1'b0; en_s4 = 1'b0; en_s5 = 1'b0;
    test_reset();
    test_full_period();
    test_enable_gating();
    test_reset_mid();
    test_small();
    test_cascade();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_counter.md
Name: vga_counter

Overview:
- Free-running modulo-N up-counter with clock enable; the basic timing element of the VGA controller.
- One instance counts horizontal pixel positions (default 11-bit, modulo 1328 = 1024 visible + 24 front porch + 136 sync + 144 back porch).
- Cascades into a vertical-line instance through its terminal-count output.
- Purely synchronous: one clock, synchronous active-high reset, no combinational path from input to counter value.

Parameters:
- WIDTH, 11, bit width of counter_output.
- COUNT_LIMIT, 11'd1328, number of states in one period; counter runs 0 .. COUNT_LIMIT-1.
  - Legal range 2 .. 2**WIDTH.
  - Elaboration fails (assertion or $error) outside this range.

Ports:
- control_clock  input  1  rising-edge clock; all state updates on this edge.
- control_reset  input  1  synchronous, active-high reset (polarity and synchronicity fixed).
- counter_enable  input  1  count-advance qualifier; counter holds when low.
- counter_output  output  WIDTH  current count, registered.
- counter_terminal  output  1  high when counter_output == COUNT_LIMIT-1 (combinational decode of the register).
- counter_carry  output  1  counter_terminal AND counter_enable; enable for a cascaded counter (wrap occurs on this edge).

Behaviour:
- Reset:
  - control_reset high at a rising edge sets counter_output to 0 on that edge, regardless of counter_enable.
  - Reset has priority over enable.
  - After reset: counter_terminal = 0 and counter_carry = 0, since COUNT_LIMIT >= 2.
- Count:
  - At a rising edge with reset low and enable high:
    - if counter_output == COUNT_LIMIT-1, next value is 0 (wrap);
    - otherwise next value is counter_output + 1.
  - At a rising edge with reset low and enable low: counter_output holds.
- Latency: counter_output changes one edge after the qualifying enable sample.
  - counter_terminal and counter_carry have zero latency relative to counter_output and counter_enable.
- Arithmetic: increment is WIDTH bits, unsigned.
  - When COUNT_LIMIT == 2**WIDTH, the wrap occurs naturally and the compare still applies.
  - Values >= COUNT_LIMIT are never reachable from reset.
- Enable held continuously: period is exactly COUNT_LIMIT clocks; counter_carry pulses for one clock per period.
- Enable toggling: count advances only on enabled edges; terminal state may persist across disabled cycles with counter_carry low.
- Reset mid-count, including in the terminal state: next value 0, no carry generated on that edge beyond the combinational value before the edge.
- Before the first reset, counter_output is X in simulation.
  - The register must not carry a declared power-on initial value; reset is required.

Decomposition:
- Shared package vga_timing_pkg holds:
  - H_TOTAL = 1328 and V_TOTAL constants;
  - the visible, front-porch, sync and back-porch widths;
  - COUNTER_WIDTH = 11.
- The counter itself uses no typedefs.
- No sub-module: a single register plus compare logic.
- The higher-level sync generator instantiates two vga_counters, with the horizontal counter_carry driving the vertical counter_enable.

Test Plan:
- Reset with enable=1: hold control_reset high 3 edges -> counter_output=0, counter_terminal=0, counter_carry=0; release -> counts 1,2,3 on the following edges.
- Full period (defaults), enable constantly 1: from 0, after 1327 edges counter_output=1327, counter_terminal=1, counter_carry=1; next edge -> 0; exactly one carry pulse per 1328 clocks, checked over 3 periods.
- Enable gating: enable pattern 1,0,0,1,0,1 from 0 -> outputs 1,1,1,2,2,3; at 1327 with enable=0, counter_terminal=1, counter_carry=0, value holds.
- Reset mid-operation: at count 700 assert reset together with enable=1 -> next value 0; at count 1327 assert reset -> 0, with no skipped or duplicated wrap afterward.
- Small-parameter instance: WIDTH=2, COUNT_LIMIT=4 -> sequence 0,1,2,3,0, exercising natural overflow; WIDTH=3, COUNT_LIMIT=5 -> 0..4,0, never 5-7.
- Cascade: horizontal (1328) carry feeds a vertical instance (WIDTH=10, COUNT_LIMIT=806) -> vertical increments exactly once per 1328 clocks and wraps to 0 after 806*1328 clocks.
